// File: rtl/and_or_pipe.sv
// Two-stage valid/ready pipeline that computes a selectable bitwise AND/OR function
// of three operands and counts the results handed to the consumer.
module and_or_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Y_any,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_AO  = 2'd2;
    localparam logic [1:0] OP_MAJ = 2'd3;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_c;
    logic [1:0]       s1_op;

    logic             out_fire;
    logic             s2_load;
    logic             s1_move;
    logic             s1_load;
    logic [WIDTH-1:0] y_next;

    // Handshake steering: a stage may refill whenever its contents are leaving.
    always_comb begin
        out_fire = out_valid & out_ready;
        s2_load  = ~out_valid | out_ready;
        s1_move  = s1_valid & s2_load;
        s1_load  = ~s1_valid | s1_move;
        in_ready = ~s1_valid | ~out_valid | out_ready;
    end

    // Result function evaluated on the S1 operands.
    always_comb begin
        y_next = '0;
        case (s1_op)
            OP_AND:  y_next = s1_a & s1_b & s1_c;
            OP_OR:   y_next = s1_a | s1_b | s1_c;
            OP_AO:   y_next = (s1_a & s1_b) | s1_c;
            OP_MAJ:  y_next = (s1_a & s1_b) | (s1_b & s1_c) | (s1_a & s1_c);
            default: y_next = '0;
        endcase
    end

    // S1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_op    <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= A;
                s1_b  <= B;
                s1_c  <= C;
                s1_op <= op;
            end
        end
    end

    // S2: result register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Y         <= '0;
            Y_any     <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                Y     <= y_next;
                Y_any <= |y_next;
            end
        end
    end

    // Delivered-result counter; clear wins over a same-cycle transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
        end else if (cnt_clr) begin
            out_count <= '0;
        end else if (out_fire) begin
            out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_and_or_pipe.sv
// Directed testbench for and_or_pipe: ops, back-to-back, backpressure, counter wrap, reset.
module tb_and_or_pipe;

    logic       clk;
    logic       rst_n;
    logic [7:0] A, B, C;
    logic [1:0] op;
    logic       in_valid;
    logic       in_ready, in_ready2;
    logic [7:0] Y, Y2;
    logic       Y_any, Y_any2;
    logic       out_valid, out_valid2;
    logic       out_ready;
    logic       cnt_clr;
    logic [15:0] out_count;
    logic [1:0]  out_count2;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    and_or_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .Y(Y), .Y_any(Y_any),
        .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
        .out_count(out_count)
    );

    and_or_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .op(op),
        .in_valid(in_valid), .in_ready(in_ready2), .Y(Y2), .Y_any(Y_any2),
        .out_valid(out_valid2), .out_ready(out_ready), .cnt_clr(cnt_clr),
        .out_count(out_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; A = 8'h00; B = 8'h00; C = 8'h00; op = 2'd0;
        in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        #12;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (Y !== 8'h00 || Y_any !== 1'b0) $display("FAIL rst_y: got %h/%b expected 00/0", Y, Y_any); else pass_cnt++;
        chk_cnt++; if (out_count !== 16'd0) $display("FAIL rst_count: got %0d expected 0", out_count); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        cycle();
    endtask

    task automatic test_ops();
        logic [7:0] exp_y [4];
        exp_y = '{8'h80, 8'hFE, 8'hEA, 8'hE8};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            A = 8'hF0; B = 8'hCC; C = 8'hAA; op = 2'(i); in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            chk_cnt++; if (out_valid !== 1'b0) $display("FAIL op%0d_latency1: got out_valid %b expected 0", i, out_valid); else pass_cnt++;
            cycle();
            chk_cnt++; if (out_valid !== 1'b1 || Y !== exp_y[i] || Y_any !== 1'b1)
                $display("FAIL op%0d_result: got %b/%h/%b expected 1/%h/1", i, out_valid, Y, Y_any, exp_y[i]); else pass_cnt++;
            cycle();
            chk_cnt++; if (out_valid !== 1'b0) $display("FAIL op%0d_drain: got out_valid %b expected 0", i, out_valid); else pass_cnt++;
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        A = 8'h00; B = 8'h00; C = 8'h00; op = 2'd1; in_valid = 1'b1;
        cycle();
        A = 8'h01;
        cycle();
        in_valid = 1'b0;
        chk_cnt++; if (out_valid !== 1'b1 || Y !== 8'h00 || Y_any !== 1'b0)
            $display("FAIL zero_any: got %b/%h/%b expected 1/00/0", out_valid, Y, Y_any); else pass_cnt++;
        cycle();
        chk_cnt++; if (out_valid !== 1'b1 || Y !== 8'h01 || Y_any !== 1'b1)
            $display("FAIL one_any: got %b/%h/%b expected 1/01/1", out_valid, Y, Y_any); else pass_cnt++;
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        out_ready = 1'b1; B = 8'h00; C = 8'h00; op = 2'd1;
        clear_cnt();
        chk_cnt++; if (out_count !== 16'd0) $display("FAIL b2b_clear: got %0d expected 0", out_count); else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 4);
            A = (k < 4) ? vals[k] : 8'h00;
            if (k < 4) begin
                chk_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready%0d: got %b expected 1", k, in_ready); else pass_cnt++;
            end
            cycle();
            if (k >= 1 && k <= 4) begin
                chk_cnt++; if (out_valid !== 1'b1 || Y !== vals[k-1])
                    $display("FAIL b2b_out%0d: got %b/%h expected 1/%h", k - 1, out_valid, Y, vals[k-1]); else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (out_count !== 16'd4) $display("FAIL b2b_count: got %0d expected 4", out_count); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        B = 8'h00; C = 8'h00; op = 2'd1;
        clear_cnt();
        out_ready = 1'b0;
        A = 8'hA1; in_valid = 1'b1;
        cycle();
        A = 8'hA2;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_accept2: got in_ready %b expected 1", in_ready); else pass_cnt++;
        cycle();
        A = 8'hA3;
        for (int k = 0; k < 3; k++) begin
            chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_full%0d: got in_ready %b expected 0", k, in_ready); else pass_cnt++;
            chk_cnt++; if (out_valid !== 1'b1 || Y !== 8'hA1)
                $display("FAIL bp_hold%0d: got %b/%h expected 1/a1", k, out_valid, Y); else pass_cnt++;
            cycle();
        end
        out_ready = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release: got in_ready %b expected 1", in_ready); else pass_cnt++;
        cycle();
        in_valid = 1'b0;
        chk_cnt++; if (out_valid !== 1'b1 || Y !== 8'hA2) $display("FAIL bp_out2: got %b/%h expected 1/a2", out_valid, Y); else pass_cnt++;
        cycle();
        chk_cnt++; if (out_valid !== 1'b1 || Y !== 8'hA3) $display("FAIL bp_out3: got %b/%h expected 1/a3", out_valid, Y); else pass_cnt++;
        cycle();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (out_count !== 16'd3) $display("FAIL bp_count: got %0d expected 3", out_count); else pass_cnt++;
    endtask

    task automatic test_wrap();
        B = 8'h00; C = 8'h00; op = 2'd1; out_ready = 1'b1;
        clear_cnt();
        for (int k = 0; k < 5; k++) begin
            A = 8'(k + 1); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();
        chk_cnt++; if (out_count2 !== 2'd1) $display("FAIL wrap_cnt2: got %0d expected 1", out_count2); else pass_cnt++;
        chk_cnt++; if (out_count !== 16'd5) $display("FAIL wrap_cnt16: got %0d expected 5", out_count); else pass_cnt++;
        A = 8'h5A; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk_cnt++; if (out_valid !== 1'b1) $display("FAIL clr_setup: got out_valid %b expected 1", out_valid); else pass_cnt++;
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        chk_cnt++; if (out_count2 !== 2'd0 || out_count !== 16'd0)
            $display("FAIL clr_with_xfer: got %0d/%0d expected 0/0", out_count2, out_count); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL clr_xfer_done: got out_valid %b expected 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        B = 8'h00; C = 8'h00; op = 2'd1; out_ready = 1'b1;
        A = 8'h3C; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        out_ready = 1'b0;
        A = 8'h01; in_valid = 1'b1;
        cycle();
        A = 8'h02;
        cycle();
        in_valid = 1'b0;
        chk_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== 16'd1)
            $display("FAIL mid_full: got %b/%b/%0d expected 1/0/1", out_valid, in_ready, out_count); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (out_valid !== 1'b0 || out_count !== 16'd0 || Y !== 8'h00 || in_ready !== 1'b1)
            $display("FAIL mid_rst: got %b/%0d/%h/%b expected 0/0/00/1", out_valid, out_count, Y, in_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_stale%0d: got out_valid %b expected 0", k, out_valid); else pass_cnt++;
        end
        A = 8'h77; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        chk_cnt++; if (out_valid !== 1'b1 || Y !== 8'h77) $display("FAIL mid_new: got %b/%h expected 1/77", out_valid, Y); else pass_cnt++;
        cycle();
    endtask

    initial begin
        test_reset();
        test_ops();
        test_zero();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
